// File: rtl/tick_div_pkg.sv
// Shared constants and helpers for the multi-channel tick/wave divider.
package tick_div_pkg;

    // Output mode encodings, one bit per channel on the mode input.
    localparam logic MODE_TOGGLE = 1'b0;  // square wave, 50% duty
    localparam logic MODE_PULSE  = 1'b1;  // one-cycle strobe mirroring tick

    // Ceiling log2, never below 1, so a single-channel build still has a
    // one-bit channel select.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_div_ch.sv
// One divider channel: free-running counter, double-buffered divisor
// (shadow + pending flag) and registered tick/wave outputs.
module tick_div_ch
    import tick_div_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 3464
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sync,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             wave
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] act_reg, act_next;
    logic [CNT_W-1:0] shd_reg, shd_next;
    logic             pend_reg, pend_next;
    logic             tick_reg, tick_next;
    logic             wave_reg, wave_next;
    logic             at_end;

    // Boundary compare; only meaningful when act is non-zero, which the
    // next-state logic guarantees before using it, so act-1 never wraps.
    assign at_end = (cnt_reg == (act_reg - CNT_W'(1)));

    // Next-state: sync beats the stopped (act==0) case, which beats counting.
    always_comb begin
        cnt_next  = cnt_reg;
        act_next  = act_reg;
        shd_next  = shd_reg;
        pend_next = pend_reg;
        tick_next = 1'b0;
        wave_next = wave_reg;

        // Writes are always captured into the shadow; last write wins.
        if (wr_sel) begin
            shd_next  = wr_div;
            pend_next = 1'b1;
        end

        if (sync) begin
            cnt_next  = '0;
            wave_next = 1'b0;
            // A same-cycle write is newer than anything pending.
            if (wr_sel) begin
                act_next  = wr_div;
                pend_next = 1'b0;
            end else if (pend_reg) begin
                act_next  = shd_reg;
                pend_next = 1'b0;
            end
        end else if (act_reg == '0) begin
            // Stopped: no boundary will ever come, so adopt a pending
            // divisor right away. A write landing now stays pending.
            cnt_next = '0;
            if (pend_reg) begin
                act_next  = shd_reg;
                pend_next = wr_sel;
            end
        end else if (en) begin
            if (at_end) begin
                cnt_next  = '0;
                tick_next = 1'b1;
                wave_next = (mode == MODE_PULSE) ? 1'b1 : ~wave_reg;
                // Write on the boundary bypasses the shadow.
                if (wr_sel) begin
                    act_next  = wr_div;
                    pend_next = 1'b0;
                end else if (pend_reg) begin
                    act_next  = shd_reg;
                    pend_next = 1'b0;
                end
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (mode != MODE_TOGGLE) begin
                    wave_next = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset to the default divisor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg  <= '0;
            act_reg  <= CNT_W'(DEF_DIV);
            shd_reg  <= CNT_W'(DEF_DIV);
            pend_reg <= 1'b0;
            tick_reg <= 1'b0;
            wave_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            act_reg  <= act_next;
            shd_reg  <= shd_next;
            pend_reg <= pend_next;
            tick_reg <= tick_next;
            wave_reg <= wave_next;
        end
    end

    assign tick = tick_reg;
    assign wave = wave_reg;

endmodule

// File: rtl/tick_div_multi.sv
// Multi-channel programmable clock-enable / square-wave generator.
// Decodes the divisor write port and replicates one channel per output bit.
module tick_div_multi
    import tick_div_pkg::*;
#(
    parameter int          CH_NUM  = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 3464,
    localparam int         CH_W    = clog2_min1(CH_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] en,
    input  logic [CH_NUM-1:0] mode,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [CH_NUM-1:0] tick,
    output logic [CH_NUM-1:0] wave
);

    // Channel selects above CH_NUM-1 match no instance and are dropped.
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic wr_sel;

        assign wr_sel = wr_en && (wr_ch == CH_W'(gi));

        tick_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[gi]),
            .mode   (mode[gi]),
            .sync   (sync),
            .wr_sel (wr_sel),
            .wr_div (wr_div),
            .tick   (tick[gi]),
            .wave   (wave[gi])
        );
    end

endmodule
